// File: rtl/force_accum.sv
// Per-body force accumulator: sums signed (fx,fy,fz) terms with saturation and emits one clipped total per body.
// Latency: out_valid rises 1 cycle after the in_last handshake; in_ready is low while a result waits in EMIT.
module force_accum #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [DATA_W-1:0] in_fx,
    input  logic signed [DATA_W-1:0] in_fy,
    input  logic signed [DATA_W-1:0] in_fz,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [DATA_W-1:0] out_fx,
    output logic signed [DATA_W-1:0] out_fy,
    output logic signed [DATA_W-1:0] out_fz,
    output logic [CNT_W-1:0]         out_cnt,
    output logic                     out_sat,
    output logic                     err_idx,
    input  logic                     clr_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT} state_t;

    localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   r_state, w_state_nx;
    logic signed [ACC_W-1:0]  r_acc_x, r_acc_y, r_acc_z;
    logic signed [ACC_W-1:0]  w_acc_x_nx, w_acc_y_nx, w_acc_z_nx;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]         r_idx, w_idx_nx;
    logic                     w_mismatch;
    logic                     w_to_emit;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] d);
        return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
    endfunction

    // One extra guard bit detects overflow; clamp instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic fits(input logic signed [ACC_W-1:0] a);
        return (&a[ACC_W-1:DATA_W-1]) || !(|a[ACC_W-1:DATA_W-1]);
    endfunction

    function automatic logic signed [DATA_W-1:0] clip(input logic signed [ACC_W-1:0] a);
        if (fits(a))
            return a[DATA_W-1:0];
        return a[ACC_W-1] ? DAT_MIN : DAT_MAX;
    endfunction

    assign in_ready = (r_state != S_EMIT);

    always_comb begin
        w_state_nx = r_state;
        w_acc_x_nx = r_acc_x;
        w_acc_y_nx = r_acc_y;
        w_acc_z_nx = r_acc_z;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_mismatch = 1'b0;
        w_to_emit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_acc_x_nx = sext(in_fx);
                    w_acc_y_nx = sext(in_fy);
                    w_acc_z_nx = sext(in_fz);
                    w_cnt_nx   = CNT_W'(1);
                    w_idx_nx   = in_idx;
                    w_to_emit  = in_last;
                    w_state_nx = in_last ? S_EMIT : S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    if (in_idx == r_idx) begin
                        w_acc_x_nx = sat_add(r_acc_x, sext(in_fx));
                        w_acc_y_nx = sat_add(r_acc_y, sext(in_fy));
                        w_acc_z_nx = sat_add(r_acc_z, sext(in_fz));
                        if (r_cnt != {CNT_W{1'b1}})
                            w_cnt_nx = r_cnt + CNT_W'(1);
                    end else begin
                        w_mismatch = 1'b1;
                    end
                    // A mismatched last term still closes the body.
                    if (in_last) begin
                        w_to_emit  = 1'b1;
                        w_state_nx = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_acc_z   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_fx    <= '0;
            out_fy    <= '0;
            out_fz    <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
            err_idx   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_acc_x <= w_acc_x_nx;
            r_acc_y <= w_acc_y_nx;
            r_acc_z <= w_acc_z_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            if (w_mismatch)
                err_idx <= 1'b1;
            else if (clr_err)
                err_idx <= 1'b0;
            // Result is captured from the post-add values so it appears one cycle after in_last.
            if (w_to_emit) begin
                out_valid <= 1'b1;
                out_idx   <= w_idx_nx;
                out_fx    <= clip(w_acc_x_nx);
                out_fy    <= clip(w_acc_y_nx);
                out_fz    <= clip(w_acc_z_nx);
                out_cnt   <= w_cnt_nx;
                out_sat   <= !fits(w_acc_x_nx) || !fits(w_acc_y_nx) || !fits(w_acc_z_nx);
            end else if (r_state == S_EMIT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
